mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single RAM port among NREQ cache-side requesters (default: core0 icache,
//  core0 dcache, core1 icache, core1 dcache). Round-robin arbitration, one RAM
//  transaction in flight, request latched at grant. Sits between the caches and RAM.
// PARAMETERS
//  NREQ   4   number of requesters (2..8); index 0 highest priority after reset
//  AW     32  address width
//  DW     32  data width
// PORTS
//  CLK        in   1        clock, rising edge
//  nRST       in   1        reset: synchronous, active-low
//  req_ren    in   NREQ     per-requester read request
//  req_wen    in   NREQ     per-requester write request
//  req_addr   in   NREQ*AW  flattened addresses; requester i at [i*AW +: AW]
//  req_store  in   NREQ*DW  flattened write data; requester i at [i*DW +: DW]
//  req_wait   out  NREQ     1 = requester i must hold its request
//  req_load   out  DW       read data, valid for the requester whose req_wait is low and whose request is active
//  req_err    out  NREQ     one-cycle pulse: transaction for i ended in RAM ERROR
//  ram_ren    out  1        RAM read strobe
//  ram_wen    out  1        RAM write strobe
//  ram_addr   out  AW       RAM address
//  ram_store  out  DW       RAM write data
//  ram_load   in   DW       RAM read data
//  ram_state  in   2        0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
//  grant      out  $clog2(NREQ)  index of current owner (debug/coherence snoop)
//  busy       out  1        1 while in state XFER
// BEHAVIOUR
//  - States: IDLE, XFER. Registers: state, grant, rr_ptr, lat_wr, lat_addr, lat_store.
//  - Reset (nRST=0 at an edge): state=IDLE, rr_ptr=0, grant=0, lat_*=0. Outputs after reset:
//    ram_ren=ram_wen=0, ram_addr=0, ram_store=0, req_err=0, busy=0, req_load=ram_load,
//    req_wait[i]=req_ren[i]|req_wen[i]. Reset mid-XFER abandons the transaction; no ack issued.
//  - active[i] = req_ren[i] | req_wen[i].
//  - IDLE: first active index searched from rr_ptr upward, wrapping mod NREQ. If found at k:
//    next state XFER, grant<=k, lat_wr<=req_wen[k], lat_addr/lat_store<=requester k's values.
//    No active requester: stay IDLE, no RAM strobes.
//  - REN and WEN both high from one requester: treated as write (lat_wr=1).
//  - XFER: ram_wen=lat_wr, ram_ren=~lat_wr, ram_addr=lat_addr, ram_store=lat_store.
//    Request changes after grant are ignored; latched copy drives RAM until completion.
//  - Completion in XFER when ram_state==ACCESS or ERROR (combinational this cycle):
//    req_wait[grant]=0 (if still active), req_load=ram_load, req_err[grant]=1 only for ERROR;
//    next state IDLE, rr_ptr<=(grant+1) mod NREQ.
//  - FREE/BUSY in XFER: stay XFER, strobes held, req_wait[grant] held high.
//  - req_wait[i]=active[i] except requester i acked this cycle. Non-owners always wait.
//  - Latency: request seen in IDLE at cycle 0 -> strobes from cycle 1. ACCESS at cycle n
//    -> ack at cycle n, IDLE at n+1. Next grant is not issued before n+2, so strobes drop
//    for at least one cycle. Requester must deassert after ack or it re-arbitrates
//    from the back of the queue.
//  - Starvation bound: a continuously active requester is granted within NREQ-1 other grants.
//  - Withdrawal: a requester that drops before ack still completes on RAM; the ack is unobserved.
// TESTING
//  1 Reset: nRST=0 with req_ren=4'b1111 -> ram_ren=0, busy=0, req_wait=4'b1111, grant=0.
//  2 Single read: req_ren[1]=1, addr=0x40, RAM ACCESS after 3 BUSY cycles, ram_load=0xDEADBEEF
//    -> ram_ren=1 cycles 1-4, ram_addr=0x40, req_wait[1]=0 and req_load=0xDEADBEEF in cycle 4.
//  3 Round-robin: all four active, ACCESS each first cycle -> grant order 0,1,2,3,0.
//    One IDLE cycle between grants.
//  4 Write precedence: req_ren[2]=req_wen[2]=1, store=0x1234 -> ram_wen=1, ram_ren=0,
//    ram_store=0x1234.
//  5 Latching: change req_addr[0] from 0x10 to 0x20 mid-XFER -> ram_addr stays 0x10 until ACCESS.
//  6 Error and reset: ram_state=ERROR -> req_err[grant] pulses 1 cycle, state IDLE.
//    nRST=0 mid-XFER -> strobes 0 next cycle, no ack.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Cache-side request bus and RAM port bundled for mem_arbiter.
// master: arbiter view; slave: requesters plus RAM.
interface mem_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = 32,
    parameter int unsigned DW   = 32
);
    logic [NREQ-1:0]    req_ren;
    logic [NREQ-1:0]    req_wen;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_store;
    logic [NREQ-1:0]    req_wait;
    logic [DW-1:0]      req_load;
    logic [NREQ-1:0]    req_err;
    logic               ram_ren;
    logic               ram_wen;
    logic [AW-1:0]      ram_addr;
    logic [DW-1:0]      ram_store;
    logic [DW-1:0]      ram_load;
    logic [1:0]         ram_state;

    modport master (
        input  req_ren, req_wen, req_addr, req_store, ram_load, ram_state,
        output req_wait, req_load, req_err, ram_ren, ram_wen, ram_addr, ram_store
    );

    modport slave (
        output req_ren, req_wen, req_addr, req_store, ram_load, ram_state,
        input  req_wait, req_load, req_err, ram_ren, ram_wen, ram_addr, ram_store
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one RAM port among NREQ cache requesters.
// One transaction in flight; the winner's request is latched at grant.
module mem_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = 32,
    parameter int unsigned DW   = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    mem_arbiter_if.master            bus_io,
    output logic [$clog2(NREQ)-1:0]  grant_o,
    output logic                     busy_o
);
    localparam int unsigned GW = $clog2(NREQ);

    typedef enum logic {StIdle, StXfer} state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            lat_wr_q, lat_wr_d;
    logic [AW-1:0]   lat_addr_q, lat_addr_d;
    logic [DW-1:0]   lat_store_q, lat_store_d;

    logic [NREQ-1:0] active;
    logic [GW-1:0]   pick;
    logic [GW-1:0]   idx;
    logic            found;
    logic            done;
    logic            err;

    assign active = bus_io.req_ren | bus_io.req_wen;
    // ACCESS (2) and ERROR (3) both end the transaction.
    assign done   = (state_q == StXfer) && bus_io.ram_state[1];
    assign err    = done && bus_io.ram_state[0];

    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int unsigned o = 0; o < NREQ; o++) begin
            idx = GW'((32'(rr_ptr_q) + o) % NREQ);
            if (!found && active[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            lat_wr_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_store_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            lat_wr_q    <= lat_wr_d;
            lat_addr_q  <= lat_addr_d;
            lat_store_q <= lat_store_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        lat_wr_d    = lat_wr_q;
        lat_addr_d  = lat_addr_q;
        lat_store_d = lat_store_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d     = StXfer;
                    grant_d     = pick;
                    lat_wr_d    = bus_io.req_wen[pick];
                    lat_addr_d  = bus_io.req_addr[32'(pick)*AW +: AW];
                    lat_store_d = bus_io.req_store[32'(pick)*DW +: DW];
                end
            end
            StXfer: begin
                if (done) begin
                    state_d  = StIdle;
                    rr_ptr_d = GW'((32'(grant_q) + 1) % NREQ);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus_io.req_wait  = active;
        bus_io.req_err   = '0;
        bus_io.req_load  = bus_io.ram_load;
        bus_io.ram_ren   = 1'b0;
        bus_io.ram_wen   = 1'b0;
        bus_io.ram_addr  = '0;
        bus_io.ram_store = '0;
        if (state_q == StXfer) begin
            bus_io.ram_wen   = lat_wr_q;
            bus_io.ram_ren   = ~lat_wr_q;
            bus_io.ram_addr  = lat_addr_q;
            bus_io.ram_store = lat_store_q;
            if (done) begin
                bus_io.req_wait[grant_q] = 1'b0;
                bus_io.req_err[grant_q]  = err;
            end
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q == StXfer);
endmodule
